// File: rtl/conv_l0_channel_scheduler.sv
// Layer-0 convolution channel scheduler.
// Steps one shared conv engine through NUM_CHANNELS kernels per frame.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   frame_start     pulse, starts a frame when idle
//   abort           level, drops the frame and returns to idle
//   eng_start       one-cycle start pulse to the conv engine
//   eng_kernel_sel  kernel index for the channel being processed
//   eng_valid_col   engine output column valid
//   eng_col_num     engine column number, 1..OUT_COLS
//   eng_done        engine completion pulse
//   res_wr_en       result memory write strobe
//   res_wr_addr     result memory column address
//   busy            high whenever the scheduler is not idle
//   frame_done      one-cycle pulse after a frame without timeout
//   err             sticky {timeout, count_mismatch, col_range}
module conv_l0_channel_scheduler #(
    parameter int NUM_CHANNELS = 4,
    parameter int OUT_COLS     = 24,
    parameter int COL_W        = 6,
    parameter int TIMEOUT      = 4096,
    localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int ADDR_W = ((NUM_CHANNELS * OUT_COLS) > 1)
                            ? $clog2(NUM_CHANNELS * OUT_COLS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              abort,
    output logic              eng_start,
    output logic [CH_W-1:0]   eng_kernel_sel,
    input  logic              eng_valid_col,
    input  logic [COL_W-1:0]  eng_col_num,
    input  logic              eng_done,
    output logic              res_wr_en,
    output logic [ADDR_W-1:0] res_wr_addr,
    output logic              busy,
    output logic              frame_done,
    output logic [2:0]        err
);

    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int OC_W  = $clog2(OUT_COLS + 1);
    // One column per cycle at most, so the count is bounded by the timer.
    localparam int CNT_W = ((TMR_W > OC_W) ? TMR_W : OC_W) + 1;

    localparam logic [COL_W:0]  COL_MAX  = (COL_W + 1)'(OUT_COLS);
    localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NUM_CHANNELS - 1);
    localparam logic [TMR_W-1:0] TMR_END = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(OUT_COLS);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        NEXT,
        FINISH
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CH_W-1:0]   ch_q;
    logic [CH_W-1:0]   ch_d;
    logic [CNT_W-1:0]  col_cnt_q;
    logic [CNT_W-1:0]  col_cnt_d;
    logic [TMR_W-1:0]  timer_q;
    logic [TMR_W-1:0]  timer_d;
    logic [2:0]        err_q;
    logic [2:0]        err_d;
    logic              wr_en_q;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] wr_addr_d;

    logic              in_range;
    logic              accept;
    logic              bad_col;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] col_off;
    logic [CNT_W-1:0]  cnt_total;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            col_cnt_q <= '0;
            timer_q   <= '0;
            err_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            col_cnt_q <= col_cnt_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    always_comb begin
        in_range  = (eng_col_num != '0) && ({1'b0, eng_col_num} <= COL_MAX);
        accept    = eng_valid_col && in_range;
        bad_col   = eng_valid_col && !in_range;
        base      = ADDR_W'(ch_q) * ADDR_W'(OUT_COLS);
        col_off   = ADDR_W'(eng_col_num) - ADDR_W'(1);
        // Column arriving together with eng_done still counts.
        cnt_total = col_cnt_q + CNT_W'(accept);

        state_d   = state_q;
        ch_d      = ch_q;
        col_cnt_d = col_cnt_q;
        timer_d   = timer_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = LAUNCH;
                    ch_d    = '0;
                    err_d   = '0;
                end
            end
            LAUNCH: begin
                col_cnt_d = '0;
                timer_d   = '0;
                state_d   = RUN;
            end
            RUN: begin
                timer_d = timer_q + TMR_W'(1);
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = base + col_off;
                    col_cnt_d = cnt_total;
                end
                if (bad_col) begin
                    err_d[0] = 1'b1;
                end
                if (eng_done) begin
                    if (cnt_total != CNT_EXP) begin
                        err_d[1] = 1'b1;
                    end
                    state_d = NEXT;
                end else if (timer_q == TMR_END) begin
                    err_d[2] = 1'b1;
                    state_d  = FINISH;
                end
            end
            NEXT: begin
                if (ch_q == CH_LAST) begin
                    state_d = FINISH;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = LAUNCH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over every transition and kills the queued write.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            wr_en_d = 1'b0;
            err_d   = err_q;
        end
    end

    assign eng_start      = (state_q == LAUNCH);
    assign eng_kernel_sel = ((state_q == LAUNCH) || (state_q == RUN))
                            ? ch_q : '0;
    assign res_wr_en      = wr_en_q;
    assign res_wr_addr    = wr_addr_q;
    assign busy           = (state_q != IDLE);
    assign frame_done     = (state_q == FINISH) && !err_q[2];
    assign err            = err_q;

endmodule

// File: tb/tb_conv_l0_channel_scheduler.sv
// Testbench for conv_l0_channel_scheduler.
// Directed engine stimulus with a queue-based scoreboard monitor.
module tb_conv_l0_channel_scheduler;

    localparam int NCH    = 4;
    localparam int OC     = 24;
    localparam int ADDR_W = 7;
    localparam int CH_W   = 2;

    typedef struct {
        int addr;
        int cyc;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_start = 1'b0;
    logic              abort = 1'b0;
    logic              eng_start;
    logic [CH_W-1:0]   eng_kernel_sel;
    logic              eng_valid_col = 1'b0;
    logic [5:0]        eng_col_num = '0;
    logic              eng_done = 1'b0;
    logic              res_wr_en;
    logic [ADDR_W-1:0] res_wr_addr;
    logic              busy;
    logic              frame_done;
    logic [2:0]        err;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    wr_t exp_wr[$];
    int  exp_k[$];
    int  exp_done[$];

    conv_l0_channel_scheduler #(
        .NUM_CHANNELS(NCH),
        .OUT_COLS(OC),
        .COL_W(6),
        .TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .abort(abort),
        .eng_start(eng_start),
        .eng_kernel_sel(eng_kernel_sel),
        .eng_valid_col(eng_valid_col),
        .eng_col_num(eng_col_num),
        .eng_done(eng_done),
        .res_wr_en(res_wr_en),
        .res_wr_addr(res_wr_addr),
        .busy(busy),
        .frame_done(frame_done),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: every write, launch and done must be expected.
    always @(negedge clk) begin : mon
        wr_t w;
        int  k;
        if (!rst) begin
            if (res_wr_en) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write actual=%0d required=none",
                             res_wr_addr);
                end else begin
                    w = exp_wr.pop_front();
                    if (int'(res_wr_addr) != w.addr || cyc != w.cyc) begin
                        errors++;
                        $display("FAIL write actual=%0d@%0d required=%0d@%0d",
                                 res_wr_addr, cyc, w.addr, w.cyc);
                    end
                end
            end
            if (eng_start) begin
                checks++;
                if (exp_k.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_start actual=%0d required=none",
                             eng_kernel_sel);
                end else begin
                    k = exp_k.pop_front();
                    if (int'(eng_kernel_sel) != k) begin
                        errors++;
                        $display("FAIL kernel_sel actual=%0d required=%0d",
                                 eng_kernel_sel, k);
                    end
                end
            end
            if (frame_done) begin
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame_done actual=1 required=0");
                end else begin
                    k = exp_done.pop_front();
                end
            end
        end
    end

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (eng_start) begin
                ok = 1'b1;
                start_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL eng_start_wait actual=none required=pulse");
        end
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        chk("busy_drop", int'(idle), 1);
    endtask

    // Modes: 0 normal, 1 done with last col, 2 short (23 cols),
    // 3 bad cols first, 4 hang, 5 abort, 6 async reset, 7 frame_start mid.
    task automatic run_ch(input int ch, input int mode);
        bit ok;
        int last;
        int diff;
        wait_start(ok);
        if (!ok) return;
        last = (mode == 2) ? 23 : (mode == 4) ? 3 :
               (mode == 5) ? 5 : (mode == 6) ? 4 : OC;
        if (mode == 3) begin
            @(negedge clk);
            eng_valid_col = 1'b1;
            eng_col_num   = 6'd0;
            @(negedge clk);
            eng_col_num   = 6'd25;
        end
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            eng_valid_col = 1'b1;
            eng_col_num   = 6'(c);
            eng_done      = (mode == 1) && (c == last);
            frame_start   = (mode == 7) && (c == 10);
            abort         = (mode == 5) && (c == last);
            if (!((mode == 5 || mode == 6) && c == last))
                exp_wr.push_back('{ch * OC + c - 1, cyc + 1});
        end
        if (mode == 6) begin
            @(posedge clk);
            #2 rst = 1'b1;
            #1;
            chk("rst_wr_en", int'(res_wr_en), 0);
            chk("rst_busy", int'(busy), 0);
            exp_wr.delete();
            exp_k.delete();
            exp_done.delete();
            @(negedge clk);
            eng_valid_col = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            return;
        end
        if (mode == 0 || mode == 2 || mode == 3 || mode == 7) begin
            @(negedge clk);
            eng_valid_col = 1'b0;
            eng_done      = 1'b1;
        end
        @(negedge clk);
        eng_valid_col = 1'b0;
        eng_done      = 1'b0;
        frame_start   = 1'b0;
        abort         = 1'b0;
        if (mode == 5) begin
            chk("abort_busy", int'(busy), 0);
        end
        if (mode == 4) begin
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (err[2]) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            diff = cyc - start_cyc;
            chk("timeout_seen", int'(ok), 1);
            chk("timeout_window", int'(diff == 64 || diff == 65), 1);
        end
    endtask

    task automatic run_frame(input int m0, input int m1, input int m2,
                             input int m3, input int nl, input bit fd,
                             input int exp_err, input string tag);
        int modes[4];
        modes = '{m0, m1, m2, m3};
        for (int i = 0; i < nl; i++) exp_k.push_back(i);
        if (fd) exp_done.push_back(1);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int i = 0; i < nl; i++) run_ch(i, modes[i]);
        wait_idle();
        chk({tag, "_err"}, int'(err), exp_err);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_start", int'(eng_start), 0);
        chk("reset_wr_en", int'(res_wr_en), 0);
        chk("reset_addr", int'(res_wr_addr), 0);
        chk("reset_done", int'(frame_done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_ksel", int'(eng_kernel_sel), 0);
        rst = 1'b0;

        @(negedge clk);
        eng_valid_col = 1'b1;
        eng_col_num   = 6'd30;
        eng_done      = 1'b1;
        @(negedge clk);
        eng_valid_col = 1'b0;
        eng_done      = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_ignore_err", int'(err), 0);
        chk("idle_ignore_busy", int'(busy), 0);

        run_frame(0, 7, 1, 1, 4, 1'b1, 0, "nominal");
        run_frame(0, 0, 2, 0, 4, 1'b1, 2, "short");
        run_frame(3, 0, 0, 0, 4, 1'b1, 1, "badcol");
        run_frame(0, 4, 0, 0, 2, 1'b0, 4, "timeout");
        run_frame(0, 5, 0, 0, 2, 1'b0, 0, "abort");
        run_frame(6, 0, 0, 0, 1, 1'b0, 0, "reset");
        run_frame(0, 0, 0, 1, 4, 1'b1, 0, "clean");

        repeat (5) @(negedge clk);
        chk("left_writes", exp_wr.size(), 0);
        chk("left_starts", exp_k.size(), 0);
        chk("left_done", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_l0_channel_scheduler.md
Name: conv_l0_channel_scheduler

Overview:
- Sequences one shared layer-0 convolution engine through NUM_CHANNELS kernels per image frame.
- For each channel it selects the kernel, pulses the engine start, tracks the output columns the engine streams back, and produces result-memory write strobes/addresses.
- Sits between the top-level frame controller and the conv engine plus its output column RAM.
- Reports frame done, busy, and sticky error status (timeout, column-count mismatch, out-of-range column).

Parameters:
- NUM_CHANNELS, 4, kernels/output channels processed per frame (>=1).
- OUT_COLS, 24, output columns expected per channel (IMAGE_SIZE-KERNEL_SIZE+1).
- COL_W, 6, width of engine column-number input.
- TIMEOUT, 4096, max cycles per channel from eng_start to eng_done.
- CH_W, $clog2(NUM_CHANNELS) (min 1), channel index width (localparam).
- ADDR_W, $clog2(NUM_CHANNELS*OUT_COLS), result-memory address width (localparam).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  pulse; begin a frame (ignored unless IDLE)
- abort  in  1  level; return to IDLE at next edge, no done
- eng_start  out  1  one-cycle start pulse to conv engine
- eng_kernel_sel  out  CH_W  kernel index for the current channel
- eng_valid_col  in  1  engine output column valid
- eng_col_num  in  COL_W  engine column number, 1..OUT_COLS
- eng_done  in  1  engine completion pulse
- res_wr_en  out  1  result memory write strobe
- res_wr_addr  out  ADDR_W  result memory column address
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse after the last channel completes cleanly
- err  out  3  sticky {timeout, count_mismatch, col_range}; cleared on an accepted frame_start

Behaviour:
- Reset values: all outputs 0; state IDLE; channel counter 0; column counter 0; timeout counter 0.
- States: IDLE, LAUNCH, RUN, NEXT, FINISH.
- IDLE: on frame_start, go to LAUNCH, set ch=0, clear err.
- LAUNCH (1 cycle): eng_start=1, eng_kernel_sel=ch; clear col_cnt and timer; go to RUN.
- eng_kernel_sel holds ch throughout LAUNCH and RUN; it is 0 in IDLE.
- RUN, column capture: each cycle with eng_valid_col=1, if 1<=eng_col_num<=OUT_COLS, register a write.
  - Next cycle: res_wr_en=1, res_wr_addr = ch*OUT_COLS + eng_col_num-1 (1-cycle latency).
  - col_cnt increments per accepted column.
  - Out-of-range column: no write; set err[0].
- RUN, timer: increments every cycle.
- RUN, on eng_done:
  - If col_cnt (including a same-cycle valid column) != OUT_COLS, set err[1].
  - Go to NEXT.
  - If eng_done and eng_valid_col coincide, the column is still written.
- RUN, timeout: if timer reaches TIMEOUT-1 without eng_done, set err[2] and go to FINISH (remaining channels skipped).
- NEXT (1 cycle): if ch==NUM_CHANNELS-1 go to FINISH, else ch++ and go to LAUNCH.
  - A pending write from the final RUN cycle issues here.
- FINISH (1 cycle): frame_done=1 only if err[2]==0; go to IDLE.
- eng_valid_col/eng_done outside RUN are ignored: no write, no error.
- frame_start while busy is ignored; no re-launch; err not cleared.
- abort in any non-IDLE state: next state IDLE, pending write dropped, no frame_done, err retained. abort has priority over all transitions.
- Async rst mid-frame: everything returns to reset values immediately; no write strobe after reset assertion.
- Address arithmetic is unsigned. ch*OUT_COLS is computed at ADDR_W width and never wraps for legal parameters.

Test Plan:
- Nominal, NUM_CHANNELS=4, OUT_COLS=24: frame_start; engine model returns cols 1..24 then eng_done per channel -> 4 eng_start pulses with kernel_sel 0,1,2,3; 96 writes at addrs 0..95, each 1 cycle after its valid; one frame_done; err=000.
- Short channel: channel 2 returns only 23 columns -> err=010 and frame_done still pulses; channel 3 still launched; addr 71 never written.
- Bad column: eng_col_num=0 and then 25 in channel 0 -> no writes for those; err[0]=1; remaining addrs correct.
- Timeout, TIMEOUT=64: engine never asserts eng_done on channel 1 -> err[2] set 64 cycles after its eng_start; FINISH with no frame_done; busy drops; channels 2-3 never launched.
- Simultaneous events: eng_done coincident with column 24 -> write to addr ch*24+23 occurs during NEXT; no mismatch flagged. frame_start while busy -> ignored.
- Abort/reset mid-frame: abort in channel 1 RUN -> IDLE next cycle, no further writes or frame_done. Async rst mid-write -> res_wr_en falls immediately; then a new frame runs cleanly with err=000.
